// File: rtl/sprite_sched.sv
// Per-line sprite scheduler: scans sprite Y positions, issues engine start pulses,
// tracks remaining lines per sprite and priority-merges engine pixels.
// Optional `define SPRITE_COLLISION_EN adds sticky per-sprite collision flags.
module sprite_sched #(
  parameter int NUM_SPR   = 4,
  parameter int HEIGHT    = 8,
  parameter int SCALE_Y   = 1,
  parameter int COLR_BITS = 4,
  parameter int TRANSP    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic                         line_start,
  input  logic [15:0]                  sy,
  input  logic [16*NUM_SPR-1:0]        spry,
  input  logic [NUM_SPR-1:0]           spr_en,
  input  logic [NUM_SPR-1:0]           drawing,
  input  logic [COLR_BITS*NUM_SPR-1:0] pix_in,
  output logic [NUM_SPR-1:0]           start,
  output logic [NUM_SPR-1:0]           active,
  output logic                         busy,
  output logic [COLR_BITS-1:0]         pix,
`ifdef SPRITE_COLLISION_EN
  output logic                         pix_valid,
  output logic [NUM_SPR-1:0]           collide
`else
  output logic                         pix_valid
`endif
);

  localparam int LINES = HEIGHT * SCALE_Y;
  localparam int CW    = $clog2(LINES + 1);
  localparam int IW    = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  cnt [NUM_SPR];

  logic [15:0]        cur_y;
  logic signed [16:0] sy_ext;
  logic signed [16:0] top_m1;
  logic               hit;

  // Widen to 17 bits so spry = -32768 gives -32769 instead of wrapping to 32767.
  always_comb begin
    cur_y  = spry[{idx, 4'b0000} +: 16];
    sy_ext = signed'({sy[15], sy});
    top_m1 = signed'({cur_y[15], cur_y}) - 17'sd1;
    hit    = (state == SCAN) && spr_en[idx] && !active[idx] && (sy_ext == top_m1);
  end

  assign busy = (state == SCAN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      start  <= '0;
      active <= '0;
      for (int i = 0; i < NUM_SPR; i++) cnt[i] <= '0;
    end else begin
      start <= '0;

      if (line_start) begin
        for (int i = 0; i < NUM_SPR; i++) begin
          if (active[i]) begin
            cnt[i] <= cnt[i] - 1'b1;
            if (cnt[i] == CW'(1)) active[i] <= 1'b0;
          end
        end
      end

      if (hit) begin
        start[idx]  <= 1'b1;
        active[idx] <= 1'b1;
        cnt[idx]    <= CW'(LINES);
      end

      case (state)
        IDLE: begin
          if (line_start) begin
            state <= SCAN;
            idx   <= '0;
          end
        end
        SCAN: begin
          if (idx == IW'(NUM_SPR - 1)) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Frame start overrides everything above, but a simultaneous line start still opens a scan.
      if (frame_start) begin
        active <= '0;
        start  <= '0;
        idx    <= '0;
        for (int i = 0; i < NUM_SPR; i++) cnt[i] <= '0;
        state  <= line_start ? SCAN : IDLE;
      end
    end
  end

  logic [NUM_SPR-1:0]   opaque;
  logic [COLR_BITS-1:0] pix_nxt;
  logic                 valid_nxt;

  // Walk from the highest index down so the lowest opaque sprite wins.
  always_comb begin
    opaque    = '0;
    pix_nxt   = '0;
    valid_nxt = 1'b0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      opaque[i] = drawing[i] && (pix_in[COLR_BITS*i +: COLR_BITS] != COLR_BITS'(TRANSP));
      if (opaque[i]) begin
        pix_nxt   = pix_in[COLR_BITS*i +: COLR_BITS];
        valid_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix       <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix       <= pix_nxt;
      pix_valid <= valid_nxt;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [NUM_SPR-1:0] multi_opaque;

  // More than one opaque bit set means every opaque sprite is colliding.
  assign multi_opaque = ((opaque & (opaque - 1'b1)) != '0) ? opaque : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collide <= '0;
    end else if (frame_start) begin
      collide <= '0;
    end else begin
      collide <= collide | multi_opaque;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_sched.sv
// Self-checking bench for sprite_sched: table-driven compositor vectors plus
// hand-written scheduler sequences (hit/countdown, clear, boundaries, reset, collisions).
module tb_sprite_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        line_start;
  logic [15:0] sy;
  logic [63:0] spry;
  logic [3:0]  spr_en;
  logic [3:0]  drawing;
  logic [15:0] pix_in;
  logic [3:0]  start;
  logic [3:0]  active;
  logic        busy;
  logic [3:0]  pix;
  logic        pix_valid;
`ifdef SPRITE_COLLISION_EN
  logic [3:0]  collide;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  sprite_sched dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .line_start  (line_start),
    .sy          (sy),
    .spry        (spry),
    .spr_en      (spr_en),
    .drawing     (drawing),
    .pix_in      (pix_in),
    .start       (start),
    .active      (active),
    .busy        (busy),
    .pix         (pix),
`ifdef SPRITE_COLLISION_EN
    .pix_valid   (pix_valid),
    .collide     (collide)
`else
    .pix_valid   (pix_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  drw;
    logic [15:0] pin;
    logic [3:0]  exp_pix;
    logic        exp_valid;
  } comp_vec_t;

  comp_vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] drw, input logic [15:0] pin);
    drawing = drw;
    pix_in  = pin;
  endtask

  task automatic set_spry(input int i, input logic [15:0] y);
    spry[16*i +: 16] = y;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Line start pulse, then let the 4-cycle scan finish.
  task automatic line_and_scan(input logic [15:0] y);
    sy = y;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    logic [3:0] exp_start [5];
    logic       exp_busy  [5];

    vecs[0] = '{4'b0000, 16'h0000, 4'h0, 1'b0};
    vecs[1] = '{4'b0110, 16'h0500, 4'h5, 1'b1};
    vecs[2] = '{4'b0110, 16'h0530, 4'h3, 1'b1};
    vecs[3] = '{4'b1000, 16'hA000, 4'hA, 1'b1};
    vecs[4] = '{4'b0001, 16'h000F, 4'hF, 1'b1};
    vecs[5] = '{4'b1110, 16'h7000, 4'h7, 1'b1};
    vecs[6] = '{4'b0000, 16'hFFFF, 4'h0, 1'b0};
    vecs[7] = '{4'b1111, 16'h1234, 4'h4, 1'b1};
    vecs[8] = '{4'b1110, 16'h1234, 4'h3, 1'b1};
    vecs[9] = '{4'b0101, 16'h0200, 4'h2, 1'b1};

    rst = 1'b1; frame_start = 0; line_start = 0; sy = 0; spry = '0;
    spr_en = 0; drawing = 0; pix_in = 0;
    #1;
    check_output("reset_start", start, 0);
    check_output("reset_active", active, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_pix", {pix_valid, pix}, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Hit and countdown
    set_spry(2, 16'd10);
    spr_en = 4'b0100;
    pulse_frame();
    sy = 16'd9; line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check_output("t1_busy", busy, 1);
    check_output("t1_start_early", start, 0);
    tick(); tick();
    check_output("t1_start_pre", start, 0);
    tick();
    check_output("t1_start", start, 4'b0100);
    check_output("t1_active", active, 4'b0100);
    tick();
    check_output("t1_start_once", start, 0);
    check_output("t1_busy_done", busy, 0);
    for (int k = 1; k <= 8; k++) begin
      sy = 16'd100; line_start = 1'b1;
      tick();
      line_start = 1'b0;
      check_output($sformatf("t1_count%0d", k), active[2], (k < 8) ? 1 : 0);
      repeat (4) tick();
    end

    // Compositor table
    for (int v = 0; v < 10; v++) begin
      apply_stimulus(vecs[v].drw, vecs[v].pin);
      tick();
      check_output($sformatf("comp%0d_pix", v), pix, vecs[v].exp_pix);
      check_output($sformatf("comp%0d_valid", v), pix_valid, vecs[v].exp_valid);
    end
    apply_stimulus(4'b0000, 16'h0000);

    // Mid-frame clear with simultaneous line start
    pulse_frame();
    set_spry(0, 16'd20); set_spry(1, 16'd20);
    spr_en = 4'b0011;
    line_and_scan(16'd19);
    tick();
    check_output("t3_active_pre", active, 4'b0011);
    sy = 16'd19; frame_start = 1'b1; line_start = 1'b1;
    tick();
    frame_start = 1'b0; line_start = 1'b0;
    check_output("t3_active_clr", active, 0);
    exp_start = '{4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0000};
    exp_busy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 5; c++) begin
      check_output($sformatf("t3_busy%0d", c), busy, exp_busy[c]);
      check_output($sformatf("t3_start%0d", c), start, exp_start[c]);
      if (c < 4) tick();
    end
    check_output("t3_active_post", active, 4'b0011);

    // Lower boundary: no wrap at -32768
    pulse_frame();
    set_spry(0, 16'h8000);
    spr_en = 4'b0001;
    sy = 16'h7FFF; line_start = 1'b1;
    tick();
    line_start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check_output($sformatf("t4_nostart%0d", c), start, 0);
      tick();
    end
    check_output("t4_noactive", active, 0);
    set_spry(0, 16'h8001);
    line_and_scan(16'h8000);
    check_output("t4_edge_hit", active, 4'b0001);

    // Line start during scan: no restart, single decrement
    pulse_frame();
    set_spry(1, 16'd50);
    spr_en = 4'b0010;
    line_and_scan(16'd49);
    tick();
    check_output("t4_act1", active, 4'b0010);
    sy = 16'd0; line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    check_output("t4_still_busy", busy, 1);
    tick(); tick();
    check_output("t4_not_restarted", busy, 0);
    for (int k = 1; k <= 6; k++) begin
      line_and_scan(16'd0);
      check_output($sformatf("t4_count%0d", k), active[1], (k < 6) ? 1 : 0);
    end

    // Reset mid-scan with a pending hit
    pulse_frame();
    set_spry(3, 16'd30);
    spr_en = 4'b1000;
    apply_stimulus(4'b0001, 16'h000F);
    sy = 16'd29; line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    check_output("t5_pix_before", pix, 4'hF);
    tick();
    rst = 1'b1;
    #1;
    check_output("t5_start", start, 0);
    check_output("t5_active", active, 0);
    check_output("t5_busy", busy, 0);
    check_output("t5_pix", {pix_valid, pix}, 0);
    apply_stimulus(4'b0000, 16'h0000);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check_output($sformatf("t5_quiet%0d", c), {busy, active, start}, 0);
    end

`ifdef SPRITE_COLLISION_EN
    pulse_frame();
    check_output("t6_clear0", collide, 0);
    apply_stimulus(4'b1001, 16'h3001);
    tick();
    check_output("t6_set", collide, 4'b1001);
    apply_stimulus(4'b0000, 16'h0000);
    tick(); tick();
    check_output("t6_hold", collide, 4'b1001);
    pulse_frame();
    check_output("t6_frame_clr", collide, 0);
    apply_stimulus(4'b0110, 16'h0550);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check_output("t6_clear_wins", collide, 0);
    apply_stimulus(4'b0001, 16'h0001);
    tick();
    check_output("t6_single", collide, 0);
    apply_stimulus(4'b0000, 16'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_sched.md
Name: sprite_sched

Overview:
- Per-line scheduler and compositor for a bank of NUM_SPR sprite line-drawing engines.
- Scans sprite Y positions at each line start and issues single-cycle start pulses to the engines.
- Tracks how many lines each active sprite has left.
- Priority-merges the engine pixel streams into one registered pixel for the video mixer.

Parameters:
NUM_SPR, 4, number of sprite engines scheduled (1..16)
HEIGHT, 8, sprite height in source rows
SCALE_Y, 1, vertical scale factor; each sprite occupies LINES = HEIGHT*SCALE_Y screen lines
COLR_BITS, 4, colour index width
TRANSP, 0, colour index treated as transparent

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
frame_start  in  1  single-cycle pulse, start of frame
line_start  in  1  single-cycle pulse, start of each line (in horizontal blank)
sy  in  16  signed current screen line
spry  in  16*NUM_SPR  signed sprite top Y; sprite i at bits [16i+15:16i]
spr_en  in  NUM_SPR  per-sprite enable
drawing  in  NUM_SPR  engine drawing flags
pix_in  in  COLR_BITS*NUM_SPR  engine pixel outputs; sprite i at [COLR_BITS*i +: COLR_BITS]
start  out  NUM_SPR  registered one-cycle start pulses to engines
active  out  NUM_SPR  sprite currently occupying lines
busy  out  1  scan in progress
pix  out  COLR_BITS  composited pixel
pix_valid  out  1  pix is an opaque sprite pixel

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: start=0, active=0, busy=0, pix=0, pix_valid=0, FSM=IDLE, all line counters=0, idx=0.
- FSM states: IDLE, SCAN.
  - IDLE -> SCAN on line_start; idx<=0.
  - SCAN: one sprite per cycle; busy=1.
  - SCAN -> IDLE after idx==NUM_SPR-1 is evaluated. Scan length is exactly NUM_SPR cycles.
- Hit condition for sprite idx in SCAN: spr_en[idx] && !active[idx] && (sy == spry[idx]-1).
  - Compare in 17-bit signed arithmetic; no wrap at spry=-32768.
- On a hit, in the following cycle:
  - start[idx]=1 for exactly one cycle;
  - active[idx] set;
  - cnt[idx] = LINES.
- At most one start bit is high in any cycle.
- Line counters: on every line_start, each active sprite's cnt decrements by 1.
  - When the decrement reaches 0, active clears in the same update.
  - A sprite cleared this way may be re-hit in the scan that follows.
- line_start while in SCAN: the scan is not restarted and the pulse is otherwise ignored; counter decrement still applies.
- frame_start, synchronous: clears active, all cnt, idx; forces IDLE; suppresses any pending start pulse.
- frame_start and line_start in the same cycle: the clear happens first, then SCAN begins with idx=0.
- spr_en deasserted mid-sprite: no effect on active/cnt; only future starts are blocked.
- Compositor, 1-cycle latency, registered:
  - pix = pix_in of the lowest index i with drawing[i] && pix_in[i] != TRANSP; pix_valid=1.
  - If no such i: pix=0, pix_valid=0.
- Reset asserted mid-operation: all state returns to reset values immediately; no start pulse is emitted after release until a new line_start hit.

Optional Feature:
SPRITE_COLLISION_EN
- Defined: adds output collide (NUM_SPR bits).
  - collide[i] is a sticky flag, set when sprite i has an opaque pixel in the same cycle as any other opaque sprite pixel.
  - Detection uses the same cycle as the compositor inputs; flags are registered alongside pix.
  - Flags are cleared by frame_start and by rst.
  - If set and clear occur in the same cycle, the clear wins.
- Not defined: no collide port; no collision logic.

Test Plan:
1. Hit and countdown:
   - Stimulus: NUM_SPR=4, LINES=8, spry[2]=10, spr_en=4'b0100, frame_start, then line_start with sy=9.
   - Response: start=4'b0100 for one cycle, 3 cycles after line_start; active[2]=1 for 8 line_starts, cleared on the 8th.
2. Priority compositing:
   - Stimulus: drawing=4'b0110, pix_in[1]=0 (transparent), pix_in[2]=5.
   - Response: next cycle pix=5, pix_valid=1.
   - Then set pix_in[1]=3: pix=3.
3. Mid-frame clear:
   - Stimulus: frame_start pulsed with line_start, while active=4'b0011.
   - Response: active=0; scan runs with busy=1 for 4 cycles; sprites with sy==spry-1 start again.
4. Boundary and line_start during scan:
   - Stimulus: spry[0]=-32768, sy=32767.
   - Response: no start.
   - Stimulus: second line_start during SCAN.
   - Response: scan not restarted; active counters decrement once.
5. Reset mid-scan:
   - Stimulus: assert rst during SCAN with a pending hit.
   - Response: start, active, busy, pix and pix_valid are 0 immediately; no pulse after release.
6. Collisions (SPRITE_COLLISION_EN):
   - Stimulus: sprites 0 and 3 opaque in the same cycle.
   - Response: collide=4'b1001, held until frame_start.
